mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 198 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit (radix-2 shift-add, restoring divide)
//
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   in_valid/in_ready    request handshake (in_ready high only in IDLE)
//   op, srca, srcb       operation and operands, captured at acceptance
//   flush                abort any operation, drop any pending result
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   result               64-bit result, held while out_valid is high

package mdu_pkg;
  typedef logic [63:0] word_t;
  typedef enum logic [3:0] {
    MDU_NOP   = 4'd0,
    MDU_MUL   = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_REM   = 4'd4,
    MDU_REMU  = 4'd5,
    MDU_MULW  = 4'd6,
    MDU_DIVW  = 4'd7,
    MDU_DIVUW = 4'd8,
    MDU_REMW  = 4'd9,
    MDU_REMUW = 4'd10
  } mdu_op_t;
endpackage

module mdu_iter
  import mdu_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  output logic    in_ready,
  input  mdu_op_t op,
  input  word_t   srca,
  input  word_t   srcb,
  input  logic    flush,
  output logic    out_valid,
  input  logic    out_ready,
  output word_t   result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic f_mul(mdu_op_t o);
    return (o == MDU_MUL) || (o == MDU_MULW);
  endfunction

  function automatic logic f_div(mdu_op_t o);
    return (o == MDU_DIV) || (o == MDU_DIVU) || (o == MDU_REM) || (o == MDU_REMU) ||
           (o == MDU_DIVW) || (o == MDU_DIVUW) || (o == MDU_REMW) || (o == MDU_REMUW);
  endfunction

  function automatic logic f_rem(mdu_op_t o);
    return (o == MDU_REM) || (o == MDU_REMU) || (o == MDU_REMW) || (o == MDU_REMUW);
  endfunction

  function automatic logic f_sdiv(mdu_op_t o);
    return (o == MDU_DIV) || (o == MDU_REM) || (o == MDU_DIVW) || (o == MDU_REMW);
  endfunction

  function automatic logic f_w(mdu_op_t o);
    return (o == MDU_MULW) || (o == MDU_DIVW) || (o == MDU_DIVUW) ||
           (o == MDU_REMW) || (o == MDU_REMUW);
  endfunction

  function automatic word_t sext32(word_t x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  state_t  state, state_n;
  mdu_op_t op_q;
  logic [6:0] cnt;
  // Shared datapath: multiply uses acc=partial product, opa=multiplier,
  // opb=multiplicand; divide uses acc=partial remainder, opa=dividend
  // shifting out / quotient shifting in, opb=divisor magnitude.
  word_t   acc, opa, opb;
  logic    neg_q, neg_r;

  // Acceptance-side decode
  logic    w_in, sgn_in, a_neg, b_neg, special;
  word_t   a_ext, b_ext, a_mag, b_mag, min_val, spec_res, ld_a, ld_b;
  logic [6:0] n_in;

  always_comb begin
    w_in    = f_w(op);
    sgn_in  = f_sdiv(op);
    n_in    = w_in ? 7'd32 : 7'd64;
    a_ext   = w_in ? (sgn_in ? sext32(srca) : {32'b0, srca[31:0]}) : srca;
    b_ext   = w_in ? (sgn_in ? sext32(srcb) : {32'b0, srcb[31:0]}) : srcb;
    a_neg   = sgn_in & a_ext[63];
    b_neg   = sgn_in & b_ext[63];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    min_val = w_in ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    special  = 1'b1;
    spec_res = '0;
    if (f_mul(op)) begin
      special = 1'b0;
    end else if (f_div(op)) begin
      if (b_ext == '0) begin
        spec_res = f_rem(op) ? (w_in ? sext32(srca) : srca) : '1;
      end else if (sgn_in && (a_ext == min_val) && (b_ext == '1)) begin
        spec_res = f_rem(op) ? '0 : (w_in ? sext32(srca) : srca);
      end else begin
        special = 1'b0;
      end
    end
    if (f_mul(op)) begin
      ld_a = srcb;
      ld_b = w_in ? {32'b0, srca[31:0]} : srca;
    end else begin
      // W dividends are left-aligned so the step logic always shifts from bit 63.
      ld_a = w_in ? {a_mag[31:0], 32'b0} : a_mag;
      ld_b = b_mag;
    end
  end

  // One iteration step and final fix-up
  logic [64:0] shifted, trial;
  word_t acc_n, opa_n, opb_n, quo, rem, fin_res;

  always_comb begin
    shifted = {acc, opa[63]};
    trial   = shifted - {1'b0, opb};
    if (f_mul(op_q)) begin
      acc_n = acc + (opa[0] ? opb : '0);
      opa_n = opa >> 1;
      opb_n = opb << 1;
    end else begin
      acc_n = trial[64] ? shifted[63:0] : trial[63:0];
      opa_n = {opa[62:0], ~trial[64]};
      opb_n = opb;
    end
    quo = f_w(op_q) ? {32'b0, opa_n[31:0]} : opa_n;
    rem = acc_n;
    if (neg_q) quo = -quo;
    if (neg_r) rem = -rem;
    if (f_mul(op_q))      fin_res = acc_n;
    else if (f_rem(op_q)) fin_res = rem;
    else                  fin_res = quo;
    if (f_w(op_q)) fin_res = sext32(fin_res);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = special ? DONE : BUSY;
      BUSY:    if (cnt == 7'd1) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= MDU_NOP;
      cnt    <= '0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_n;
      if (!flush) begin
        case (state)
          IDLE: if (in_valid) begin
            op_q  <= op;
            cnt   <= n_in;
            acc   <= '0;
            opa   <= ld_a;
            opb   <= ld_b;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (special) result <= spec_res;
          end
          BUSY: begin
            cnt <= cnt - 7'd1;
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            if (cnt == 7'd1) result <= fin_res;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter
module tb_mdu_iter;
  import mdu_pkg::*;

  logic    clk = 1'b0;
  logic    reset, in_valid, in_ready, flush, out_valid, out_ready;
  mdu_op_t op;
  word_t   srca, srcb, result;

  int tests_run = 0;
  int fails = 0;

  mdu_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .srca(srca), .srcb(srcb), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic start_op(input mdu_op_t o, input word_t a, input word_t b);
    @(negedge clk);
    op = o; srca = a; srcb = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = MDU_DIV;
    srca = {$urandom, $urandom};
    srcb = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    op = MDU_NOP; srca = '0; srcb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_hold: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'h0) begin
      fails++;
      $display("FAIL reset_after: out_valid=%b in_ready=%b result=%h expected 0/1/0",
               out_valid, in_ready, result);
    end
  endtask

  task automatic test_mul();
    mdu_op_t ops[4] = '{MDU_MUL, MDU_MUL, MDU_MULW, MDU_MULW};
    word_t   as[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd12345, 64'hABCD_0000_7FFF_FFFF, 64'd5};
    word_t   bs[4]  = '{64'd3, 64'd1000, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
    word_t   ex[4]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd12345000,
                       64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF1};
    int      el[4]  = '{64, 64, 32, 32};
    int lat;
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_valid(lat);
      tests_run++;
      if (lat !== el[i]) begin
        fails++;
        $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, el[i]);
      end
      tests_run++;
      if (result !== ex[i]) begin
        fails++;
        $display("FAIL mul_result[%0d]: got %h expected %h", i, result, ex[i]);
      end
      if (lat >= 0) take();
    end
  endtask

  task automatic test_div();
    mdu_op_t ops[6] = '{MDU_REM, MDU_DIV, MDU_REMUW, MDU_DIVUW, MDU_DIVU, MDU_DIVW};
    word_t   as[6]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_FFFF_FFFF,
                       64'h0000_0000_8000_0000, 64'd100, 64'h0000_0000_FFFF_FFF9};
    word_t   bs[6]  = '{64'd2, 64'd2, 64'd2, 64'd1, 64'd7, 64'h0000_0000_0000_0002};
    word_t   ex[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1,
                       64'hFFFF_FFFF_8000_0000, 64'd14, 64'hFFFF_FFFF_FFFF_FFFD};
    int      el[6]  = '{64, 64, 32, 32, 64, 32};
    int lat;
    for (int i = 0; i < 6; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_valid(lat);
      tests_run++;
      if (lat !== el[i]) begin
        fails++;
        $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, el[i]);
      end
      tests_run++;
      if (result !== ex[i]) begin
        fails++;
        $display("FAIL div_result[%0d]: got %h expected %h", i, result, ex[i]);
      end
      if (lat >= 0) take();
    end
  endtask

  task automatic test_special();
    mdu_op_t ops[8] = '{MDU_DIVW, MDU_REMW, MDU_DIVU, MDU_REM, MDU_DIV, MDU_DIVUW,
                        MDU_NOP, mdu_op_t'(4'hF)};
    word_t   as[8]  = '{64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'h1234_5678_9ABC_DEF0,
                       64'hFFFF_FFFF_FFFF_FFF9, 64'h8000_0000_0000_0000, 64'd5, 64'd9, 64'd9};
    word_t   bs[8]  = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd0, 64'd0,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 64'd3, 64'd3};
    word_t   ex[8]  = '{64'hFFFF_FFFF_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                       64'hFFFF_FFFF_FFFF_FFF9, 64'h8000_0000_0000_0000,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
    int lat;
    for (int i = 0; i < 8; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_valid(lat);
      tests_run++;
      if (lat !== 0) begin
        fails++;
        $display("FAIL special_latency[%0d]: got %0d expected 0", i, lat);
      end
      tests_run++;
      if (result !== ex[i]) begin
        fails++;
        $display("FAIL special_result[%0d]: got %h expected %h", i, result, ex[i]);
      end
      if (lat >= 0) take();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(MDU_REMU, 64'd100, 64'd7);
    wait_valid(lat);
    tests_run++;
    if (lat !== 64 || result !== 64'd2) begin
      fails++;
      $display("FAIL b2b_first: lat=%0d result=%h expected 64/%h", lat, result, 64'd2);
    end
    out_ready = 1'b1; in_valid = 1'b1; op = MDU_MUL; srca = 64'd6; srcb = 64'd7;
    tests_run++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_in_ready_done: got %b expected 0", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_no_same_edge: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(lat);
    tests_run++;
    if (lat !== 64 || result !== 64'd42) begin
      fails++;
      $display("FAIL b2b_second: lat=%0d result=%h expected 64/%h", lat, result, 64'd42);
    end
    if (lat >= 0) take();
  endtask

  task automatic test_hold();
    int lat;
    start_op(MDU_DIVU, 64'd100, 64'd7);
    wait_valid(lat);
    tests_run++;
    if (lat !== 64) begin
      fails++;
      $display("FAIL hold_latency: got %0d expected 64", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (result !== 64'd14 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_cycle[%0d]: result=%h out_valid=%b in_ready=%b expected %h/1/0",
                 i, result, out_valid, in_ready, 64'd14);
      end
    end
    take();
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_flush();
    int lat;
    logic seen;
    seen = 1'b0;
    start_op(MDU_MUL, 64'h123, 64'h456);
    repeat (9) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_no_valid: out_valid seen=%b expected 0", seen);
    end
    in_valid = 1'b1; flush = 1'b1; op = MDU_MUL; srca = 64'd2; srcb = 64'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_over_accept: in_ready=%b expected 1", in_ready);
    end
    start_op(MDU_MULW, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_valid(lat);
    tests_run++;
    if (lat !== 32 || result !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      fails++;
      $display("FAIL flush_then_mulw: lat=%0d result=%h expected 32/%h",
               lat, result, 64'hFFFF_FFFF_FFFF_FFF1);
    end
    if (lat >= 0) take();
  endtask

  task automatic test_reset_mid_busy();
    logic seen;
    seen = 1'b0;
    start_op(MDU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'h0) begin
      fails++;
      $display("FAIL reset_mid_busy: in_ready=%b out_valid=%b result=%h expected 1/0/0",
               in_ready, out_valid, result);
    end
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_valid: out_valid seen=%b expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_hold();
    test_flush();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
